// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and the misalignment helper for the memory arbiter
package mem_arb_pkg;
    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;
    typedef enum logic [1:0] {
        IDLE,
        I_RESP,
        D_RESP,
        D_ERR
    } resp_state_e;
    // Words need both low address bits clear, halfwords (signed or unsigned) need bit 0 clear.
    function automatic logic is_misaligned(input logic [1:0] addr, input logic [2:0] size);
        return (size == SZ_W && addr != 2'b00) ||
               ((size == SZ_H || size == SZ_HU) && addr[0]);
    endfunction
endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// starve_counter: saturating count of consecutive denied fetch cycles
module starve_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam int W = $clog2(MAX_WAIT + 1);
    logic [W-1:0] r_cnt;
    assign sat = r_cnt == W'(MAX_WAIT);
    // Clear has priority; hold once saturated so fetch keeps winning until served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt <= '0;
        else      r_cnt <= clr ? '0 : (inc && !sat) ? r_cnt + 1'b1 : r_cnt;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between fetch and load/store ports
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic              iGnt,
    output logic              iRvalid,
    output logic [DATA_W-1:0] iRdata,
    input  logic              dReq,
    input  logic              dWen,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    input  logic [2:0]        dSize,
    output logic              dGnt,
    output logic              dRvalid,
    output logic [DATA_W-1:0] dRdata,
    output logic              dErr,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic              memWen,
    output logic [2:0]        memSize,
    input  logic [DATA_W-1:0] memRdata
);
    logic        w_sat;
    logic        w_mis;
    resp_state_e r_state;
    resp_state_e w_next;

    assign w_mis = is_misaligned(dAddr[1:0], dSize);
    // Grants are held low during reset so nothing reaches memory while rst is asserted.
    assign iGnt  = rst & iReq & (w_sat | ~dReq);
    assign dGnt  = rst & dReq & ~iGnt;

    starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (iReq & ~iGnt),
        .clr (iGnt | ~iReq),
        .sat (w_sat)
    );

    // Memory port mux; a misaligned data access degrades to a harmless read.
    always_comb begin
        memAddr  = iGnt ? iAddr : dGnt ? dAddr : '0;
        memWdata = dGnt ? dWdata : '0;
        memWen   = dGnt & dWen & ~w_mis;
        memSize  = iGnt ? 3'(SZ_W) : dGnt ? dSize : 3'b000;
    end

    // Next response owner, decided from this cycle's grant.
    always_comb begin
        w_next = iGnt ? I_RESP : !dGnt ? IDLE : w_mis ? D_ERR : !dWen ? D_RESP : IDLE;
    end

    // Response state register; reset discards any pending response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    assign iRvalid = r_state == I_RESP;
    assign iRdata  = iRvalid ? memRdata : '0;
    assign dRvalid = r_state == D_RESP || r_state == D_ERR;
    assign dErr    = r_state == D_ERR;
    assign dRdata  = r_state == D_RESP ? memRdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        iReq, iGnt, iRvalid;
    logic [31:0] iAddr, iRdata;
    logic        dReq, dWen, dGnt, dRvalid, dErr;
    logic [31:0] dAddr, dWdata, dRdata;
    logic [2:0]  dSize;
    logic [31:0] memAddr, memWdata, memRdata;
    logic        memWen;
    logic [2:0]  memSize;
    logic [31:0] mem [256];
    logic [31:0] exp_i [$];
    logic [32:0] exp_d [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .iReq(iReq), .iAddr(iAddr), .iGnt(iGnt), .iRvalid(iRvalid), .iRdata(iRdata),
        .dReq(dReq), .dWen(dWen), .dAddr(dAddr), .dWdata(dWdata), .dSize(dSize),
        .dGnt(dGnt), .dRvalid(dRvalid), .dRdata(dRdata), .dErr(dErr),
        .memAddr(memAddr), .memWdata(memWdata), .memWen(memWen), .memSize(memSize),
        .memRdata(memRdata)
    );

    // Unified word memory: preloaded with 0xA0A00000+index while reset is held.
    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'hA0A0_0000 + k;
        end else if (memWen) begin
            mem[memAddr[9:2]] <= memWdata;
        end
        memRdata <= mem[memAddr[9:2]];
    end

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT presents one.
    always @(negedge clk) begin
        #1;
        if (iRvalid) begin
            if (exp_i.size() == 0) chk("unexpected iRvalid", 33'(iRdata), 33'h1_FFFF_FFFF);
            else chk("iRdata", 33'(iRdata), 33'(exp_i.pop_front()));
        end else chk("iRdata idle", 33'(iRdata), 33'h0);
        if (dRvalid) begin
            if (exp_d.size() == 0) chk("unexpected dRvalid", {dErr, dRdata}, 33'h1_FFFF_FFFF);
            else chk("dErr/dRdata", {dErr, dRdata}, exp_d.pop_front());
        end else chk("d idle", {dErr, dRdata}, 33'h0);
    end

    // One cycle of stimulus; erk selects which response (none/fetch/data) this grant must produce.
    task automatic step(input string nm, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dwd, input logic [2:0] ds,
                        input logic eig, input logic edg, input logic ewen,
                        input int erk, input logic eerr, input logic [31:0] erd);
        iReq = ir; iAddr = ia; dReq = dr; dWen = dw; dAddr = da; dWdata = dwd; dSize = ds;
        @(negedge clk);
        chk({nm, " iGnt"}, 33'(iGnt), 33'(eig));
        chk({nm, " dGnt"}, 33'(dGnt), 33'(edg));
        chk({nm, " memWen"}, 33'(memWen), 33'(ewen));
        chk({nm, " memAddr"}, 33'(memAddr), 33'(eig ? ia : edg ? da : 32'h0));
        if (erk == 1) exp_i.push_back(erd);
        if (erk == 2) exp_d.push_back({eerr, erd});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm);
        step(nm, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        iReq = 1; iAddr = 32'h10; dReq = 1; dWen = 1; dAddr = 32'h20; dWdata = 32'h5; dSize = 3'b010;
        @(negedge clk);
        chk("reset grants", {31'h0, iGnt, dGnt}, 33'h0);
        chk("reset mem", {memWen, memAddr}, 33'h0);
        chk("reset memW", {memSize, memWdata[29:0]}, 33'h0);
        iReq = 0; dReq = 0; dWen = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        // Back-to-back fetches.
        step("fetch0", 1, 32'h0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 1, 0, 32'hA0A0_0000);
        step("fetch4", 1, 32'h4, 0, 0, 0, 0, 3'b000, 1, 0, 0, 1, 0, 32'hA0A0_0001);
        step("fetch8", 1, 32'h8, 0, 0, 0, 0, 3'b000, 1, 0, 0, 1, 0, 32'hA0A0_0002);
        idle("idle1");
        // Starvation: four data grants, then fetch, then data again.
        for (int c = 1; c <= 4; c++)
            step($sformatf("starve d%0d", c), 1, 32'hC, 1, 0, 32'h10, 0, 3'b010, 0, 1, 0, 2, 0, 32'hA0A0_0004);
        step("starve i", 1, 32'hC, 1, 0, 32'h10, 0, 3'b010, 1, 0, 0, 1, 0, 32'hA0A0_0003);
        step("starve resume", 1, 32'hC, 1, 0, 32'h14, 0, 3'b010, 0, 1, 0, 2, 0, 32'hA0A0_0005);
        idle("idle2");
        // Store then load back.
        step("store", 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 1, 1, 0, 0, 0);
        step("load back", 0, 0, 1, 0, 32'h100, 0, 3'b010, 0, 1, 0, 2, 0, 32'hDEADBEEF);
        // Misaligned store is granted, blocked from memory, and reported.
        step("mis store", 0, 0, 1, 1, 32'h102, 32'h12345678, 3'b010, 0, 1, 0, 2, 1, 32'h0);
        step("load unchanged", 0, 0, 1, 0, 32'h100, 0, 3'b010, 0, 1, 0, 2, 0, 32'hDEADBEEF);
        step("half 103", 0, 0, 1, 0, 32'h103, 0, 3'b001, 0, 1, 0, 2, 1, 32'h0);
        step("half 102", 0, 0, 1, 0, 32'h102, 0, 3'b001, 0, 1, 0, 2, 0, 32'hDEADBEEF);
        step("halfu 101", 0, 0, 1, 0, 32'h101, 0, 3'b101, 0, 1, 0, 2, 1, 32'h0);
        step("byte 103", 0, 0, 1, 0, 32'h103, 0, 3'b000, 0, 1, 0, 2, 0, 32'hDEADBEEF);
        idle("idle3");
        // Reset right after a fetch grant drops the pending response.
        step("fetch pre-rst", 1, 32'h4, 0, 0, 0, 0, 3'b000, 1, 0, 0, 1, 0, 32'hA0A0_0001);
        rst = 1'b0;
        exp_i.delete();
        iReq = 1; iAddr = 32'h8;
        @(negedge clk);
        chk("mid-rst iRvalid", 33'(iRvalid), 33'h0);
        chk("mid-rst iGnt", 33'(iGnt), 33'h0);
        chk("mid-rst mem", {memWen, memAddr}, 33'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        step("post-rst fetch", 1, 32'h8, 0, 0, 0, 0, 3'b000, 1, 0, 0, 1, 0, 32'hA0A0_0002);
        idle("idle4");
        idle("idle5");
        chk("queues drained", 33'(exp_i.size() + exp_d.size()), 33'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
